nor_vector_sequencer: RTL

NOR_VECTOR_SEQUENCER -- requirements
Module: nor_vector_sequencer

---
 rtl/nor_vector_sequencer_if.sv | 26 ++
 rtl/nor_vector_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/nor_vector_sequencer_if.sv
// Handshake and test-vector bus between the NOR sequencer and the gate under test.
interface nor_vector_sequencer_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] vec_idx;

  // Controller / test environment side
  modport master (
    output start, e,
    input  a, b, c, d, busy, done, pass, err_cnt, vec_idx
  );

  // Sequencer side
  modport slave (
    input  start, e,
    output a, b, c, d, busy, done, pass, err_cnt, vec_idx
  );
endinterface

// File: rtl/nor_vector_sequencer.sv
// Exhaustive 4-input NOR gate tester: walks vectors 0000..1111, holds each
// for HOLD_CYCLES cycles, samples e on the last hold edge and counts mismatches.
module nor_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nor_vector_sequencer_if.slave   bus
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned ERR_W  = 5;
  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mismatch_c;

  // Gate response differs from the ideal NOR of the vector currently driven
  assign mismatch_c = (bus.e != ~|vec_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        vec_d  = '0;
        if (bus.start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          // Last hold cycle of this vector: the only edge where e counts
          if (mismatch_c) begin
            err_d = err_q + ERR_W'(1);
          end
          hold_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        vec_d   = '0;
        hold_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a       = vec_q[3];
  assign bus.b       = vec_q[2];
  assign bus.c       = vec_q[1];
  assign bus.d       = vec_q[0];
  assign bus.vec_idx = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

endmodule
